// File: rtl/multi_oneshot_pkg.sv
// multi_oneshot_pkg: shared edge-select encodings, parameter limits and the
// edge-select decode helper used by every channel of multi_oneshot.
package multi_oneshot_pkg;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;
  localparam logic [1:0] EDGE_NONE = 2'b11;

  localparam int PULSE_W_MIN = 1;
  localparam int PULSE_W_MAX = 255;
  localparam int N_CH_MIN    = 1;
  localparam int N_CH_MAX    = 32;

  // Reduce the rise/fall strobes of one channel to the edge the user selected.
  function automatic logic edge_hit(input logic [1:0] sel,
                                    input logic       rise,
                                    input logic       fall);
    case (sel)
      EDGE_RISE: return rise;
      EDGE_FALL: return fall;
      EDGE_BOTH: return rise | fall;
      EDGE_NONE: return 1'b0;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/oneshot_chan.sv
// oneshot_chan: one edge-to-pulse channel (optional input synchroniser,
// previous-sample register, pulse down-counter, sticky missed-edge flag).
// Build option: MULTI_ONESHOT_SYNC_EN adds a two-flop synchroniser in front
// of the edge detector (two extra cycles of latency).
module oneshot_chan
  import multi_oneshot_pkg::*;
#(
  parameter int PULSE_W = 1,
  parameter int CNT_W   = $clog2(PULSE_W + 1)
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic       i_pulse,
  input  logic [1:0] i_edge_sel,
  input  logic       i_retrig,
  input  logic       i_clr_missed,
  output logic       o_pulse,
  output logic       o_pulse_next,
  output logic       o_missed
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             samp_s;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pulse_q;
  logic             pulse_d;
  logic             missed_q;
  logic             missed_d;
  logic             miss_set_s;
  logic             trig_s;

`ifdef MULTI_ONESHOT_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  // Two-flop synchroniser so asynchronous inputs can be sampled safely.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_pulse;
      sync2_q <= sync1_q;
    end
  end

  assign samp_s = sync2_q;
`else
  assign samp_s = i_pulse;
`endif

  assign trig_s = edge_hit(i_edge_sel, samp_s & ~prev_q, ~samp_s & prev_q) & i_en;

  // Counter reload/decrement and missed-edge detection for the coming edge.
  always_comb begin
    cnt_d      = cnt_q;
    miss_set_s = 1'b0;
    if (trig_s) begin
      // A trigger on the last active cycle counts as fresh: the pulse simply
      // continues without a gap and nothing is reported as missed.
      if (cnt_q <= CNT_ONE) begin
        cnt_d = CNT_LOAD;
      end else if (i_retrig) begin
        cnt_d = CNT_LOAD;
      end else begin
        cnt_d      = cnt_q - CNT_ONE;
        miss_set_s = 1'b1;
      end
    end else if (cnt_q != CNT_ZERO) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    // Setting the sticky flag wins over a simultaneous clear request.
    if (miss_set_s) begin
      missed_d = 1'b1;
    end else if (i_clr_missed) begin
      missed_d = 1'b0;
    end else begin
      missed_d = missed_q;
    end

    pulse_d = (cnt_d != CNT_ZERO);
  end

  // Channel state registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      prev_q   <= 1'b0;
      cnt_q    <= CNT_ZERO;
      pulse_q  <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      prev_q   <= samp_s;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      missed_q <= missed_d;
    end
  end

  assign o_pulse      = pulse_q;
  assign o_pulse_next = pulse_d;
  assign o_missed     = missed_q;

endmodule

// File: rtl/multi_oneshot.sv
// multi_oneshot: N_CH independent edge-to-pulse channels plus a registered
// any-channel-active flag. Build option: MULTI_ONESHOT_SYNC_EN (per-channel
// input synchroniser, handled inside oneshot_chan).
module multi_oneshot
  import multi_oneshot_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int PULSE_W = 1,
  parameter int CNT_W   = $clog2(PULSE_W + 1)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_en,
  input  logic [N_CH-1:0] i_pulse,
  input  logic [1:0]      i_edge_sel,
  input  logic            i_retrig,
  input  logic            i_clr_missed,
  output logic [N_CH-1:0] o_pulse,
  output logic            o_any,
  output logic [N_CH-1:0] o_missed
);

  logic [N_CH-1:0] pulse_next_s;
  logic            any_q;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_chan
    oneshot_chan #(
      .PULSE_W (PULSE_W),
      .CNT_W   (CNT_W)
    ) u_chan (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_en         (i_en),
      .i_pulse      (i_pulse[ch]),
      .i_edge_sel   (i_edge_sel),
      .i_retrig     (i_retrig),
      .i_clr_missed (i_clr_missed),
      .o_pulse      (o_pulse[ch]),
      .o_pulse_next (pulse_next_s[ch]),
      .o_missed     (o_missed[ch])
    );
  end

  // Registering the OR of the next-state pulses keeps o_any cycle-aligned
  // with |o_pulse without a combinational path on the output.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |pulse_next_s;
    end
  end

  assign o_any = any_q;

endmodule

// File: tb/tb_multi_oneshot.sv
// tb_multi_oneshot: directed table, hand-written corner sequences and random
// stimulus for multi_oneshot, using two instances (PULSE_W=4 and PULSE_W=1).
module tb_multi_oneshot;

`ifdef MULTI_ONESHOT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       retrig;
  logic       clr;
  logic [3:0] pin;
  logic [1:0] sel;
  logic [3:0] p4, m4, p1, m1;
  logic       a4, a1;

  always #5 clk = ~clk;

  multi_oneshot #(.N_CH(4), .PULSE_W(4)) dut4 (
    .i_clk(clk), .i_reset(rst_n), .i_en(en), .i_pulse(pin), .i_edge_sel(sel),
    .i_retrig(retrig), .i_clr_missed(clr), .o_pulse(p4), .o_any(a4), .o_missed(m4)
  );

  multi_oneshot #(.N_CH(4), .PULSE_W(1)) dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_en(en), .i_pulse(pin), .i_edge_sel(sel),
    .i_retrig(retrig), .i_clr_missed(clr), .o_pulse(p1), .o_any(a1), .o_missed(m1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: each channel remembers the edge index at which its pulse
  // ends; it is active after edge t while t < end.
  int         tcur = 0;
  int         busy_end [2][4];
  bit         mmiss    [2][4];
  logic [3:0] mprev = 4'b0;
  logic [3:0] pipe1 = 4'b0;
  logic [3:0] pipe2 = 4'b0;
  logic [3:0] ep [2];
  logic [3:0] em [2];

  task automatic model_edge();
    logic [3:0] eff;
    int         pw;
    bit         rise, fall, hit;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < 4; c++) begin busy_end[d][c] = 0; mmiss[d][c] = 0; end
      mprev = 4'b0; pipe1 = 4'b0; pipe2 = 4'b0;
    end else begin
      eff   = (LAT == 2) ? pipe2 : pin;
      pipe2 = pipe1;
      pipe1 = pin;
      for (int d = 0; d < 2; d++) begin
        pw = (d == 0) ? 4 : 1;
        for (int c = 0; c < 4; c++) begin
          rise = eff[c] && !mprev[c];
          fall = !eff[c] && mprev[c];
          case (sel)
            2'b00:   hit = rise;
            2'b01:   hit = fall;
            2'b10:   hit = rise || fall;
            default: hit = 1'b0;
          endcase
          if (hit && en) begin
            if (busy_end[d][c] <= tcur || retrig) busy_end[d][c] = tcur + pw;
            else mmiss[d][c] = 1'b1;
          end else if (clr) begin
            mmiss[d][c] = 1'b0;
          end
          if (hit && en && clr && !(busy_end[d][c] > tcur + pw - 1 && !retrig) && busy_end[d][c] == tcur + pw)
            mmiss[d][c] = 1'b0;
        end
      end
      mprev = eff;
    end
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) begin
        ep[d][c] = (tcur < busy_end[d][c]);
        em[d][c] = mmiss[d][c];
      end
    tcur++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("pulse_w4",  p4, ep[0]);
    chk("any_w4",    a4, |ep[0]);
    chk("missed_w4", m4, em[0]);
    chk("pulse_w1",  p1, ep[1]);
    chk("any_w1",    a1, |ep[1]);
    chk("missed_w1", m1, em[1]);
  endtask

  typedef struct {
    logic       r;
    logic       e;
    logic [1:0] s;
    logic       rt;
    logic       cl;
    logic       p;
    logic       exp_p;
    logic       exp_m;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic [1:0] s, input logic rt,
                     input logic cl, input logic p, input logic xp, input logic xm);
    vec_t v;
    v.r = r; v.e = e; v.s = s; v.rt = rt; v.cl = cl; v.p = p; v.exp_p = xp; v.exp_m = xm;
    tbl.push_back(v);
  endtask

  int hits[$];

  initial begin
    rst_n = 1'b0; en = 1'b1; retrig = 1'b0; clr = 1'b0; pin = 4'b0; sel = 2'b00;
    #2;

`ifndef MULTI_ONESHOT_SYNC_EN
    // reset with input held high, then one PULSE_W=4 pulse
    add(0,1,2'b00,0,0,1, 0,0); add(0,1,2'b00,0,0,1, 0,0);
    add(1,1,2'b00,0,0,1, 1,0); add(1,1,2'b00,0,0,1, 1,0); add(1,1,2'b00,0,0,1, 1,0);
    add(1,1,2'b00,0,0,1, 1,0); add(1,1,2'b00,0,0,1, 0,0); add(1,1,2'b00,0,0,0, 0,0);
    // second rise while busy, no retrigger: missed, then cleared
    add(1,1,2'b00,0,0,1, 1,0); add(1,1,2'b00,0,0,0, 1,0); add(1,1,2'b00,0,0,1, 1,1);
    add(1,1,2'b00,0,0,1, 1,1); add(1,1,2'b00,0,0,0, 0,1); add(1,1,2'b00,0,1,0, 0,0);
    add(1,1,2'b00,0,0,0, 0,0);
    // same with retrigger: 6 continuous cycles
    add(1,1,2'b00,1,0,1, 1,0); add(1,1,2'b00,1,0,0, 1,0); add(1,1,2'b00,1,0,1, 1,0);
    add(1,1,2'b00,1,0,1, 1,0); add(1,1,2'b00,1,0,1, 1,0); add(1,1,2'b00,1,0,1, 1,0);
    add(1,1,2'b00,1,0,1, 0,0);
    // reset mid-pulse
    add(1,1,2'b00,0,0,0, 0,0); add(1,1,2'b00,0,0,1, 1,0); add(1,1,2'b00,0,0,0, 1,0);
    add(1,1,2'b00,0,0,1, 1,1); add(0,1,2'b00,0,0,1, 0,0); add(1,1,2'b00,0,0,0, 0,0);
    // enable low blocks, falling edge, then NONE lets pulse finish
    add(1,0,2'b00,0,0,1, 0,0); add(1,1,2'b00,0,0,1, 0,0); add(1,1,2'b01,0,0,0, 1,0);
    add(1,1,2'b11,0,0,1, 1,0); add(1,1,2'b11,0,0,0, 1,0); add(1,1,2'b11,0,0,0, 1,0);
    add(1,1,2'b11,0,0,0, 0,0);
    // set beats clear in the same cycle
    add(1,1,2'b00,0,0,1, 1,0); add(1,1,2'b00,0,0,0, 1,0); add(1,1,2'b00,0,1,1, 1,1);
    add(1,1,2'b00,0,0,0, 1,1); add(1,1,2'b00,0,0,0, 0,1); add(1,1,2'b00,0,1,0, 0,0);
    // edge on the final active cycle: fresh trigger, never missed
    add(1,1,2'b00,0,0,1, 1,0); add(1,1,2'b00,0,0,0, 1,0); add(1,1,2'b00,0,0,0, 1,0);
    add(1,1,2'b00,0,0,0, 1,0); add(1,1,2'b00,0,0,1, 1,0); add(1,1,2'b00,0,0,0, 1,0);
    add(1,1,2'b00,0,0,0, 1,0); add(1,1,2'b00,0,0,0, 1,0); add(1,1,2'b00,0,0,0, 0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].r; en = tbl[i].e; sel = tbl[i].s; retrig = tbl[i].rt;
      clr = tbl[i].cl; pin = {3'b000, tbl[i].p};
      step();
      chk($sformatf("tbl%0d_pulse0", i), p4[0], tbl[i].exp_p);
      chk($sformatf("tbl%0d_any", i), a4, tbl[i].exp_p);
      chk($sformatf("tbl%0d_missed0", i), m4[0], tbl[i].exp_m);
    end
`endif

    rst_n = 1'b0; pin = 4'b0; en = 1'b1; sel = 2'b00; retrig = 1'b0; clr = 1'b0;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // both edges, PULSE_W=1, channel 1 high for 3 cycles
    sel = 2'b10;
    hits.delete();
    for (int i = 0; i < 10; i++) begin
      pin[1] = (i < 3);
      step();
      if (p1[1]) hits.push_back(i);
    end
    chk("both_count", hits.size(), 2);
    if (hits.size() == 2) begin
      chk("both_first", hits[0], LAT);
      chk("both_gap", hits[1] - hits[0], 3);
    end

    // NONE selection and global disable: no pulse at all
    for (int k = 0; k < 2; k++) begin
      sel = (k == 0) ? 2'b11 : 2'b10;
      en  = (k == 0);
      hits.delete();
      for (int i = 0; i < 10; i++) begin
        pin[1] = (i < 3);
        step();
        if (p1[1]) hits.push_back(i);
      end
      chk(k == 0 ? "none_count" : "en0_count", hits.size(), 0);
    end

    // latency of a rising edge on channel 3
    sel = 2'b00; en = 1'b1; pin = 4'b0;
    for (int i = 0; i < 4; i++) step();
    pin[3] = 1'b1;
    for (int i = 0; i <= LAT; i++) begin
      step();
      if (i < LAT) chk("lat_low", p4[3], 1'b0);
      else begin
        chk("lat_high", p4[3], 1'b1);
        chk("lat_any", a4, 1'b1);
      end
    end

    // random stimulus against the model
    for (int i = 0; i < 800; i++) begin
      rst_n  = ($urandom_range(0, 49) != 0);
      en     = ($urandom_range(0, 7) != 0);
      sel    = 2'($urandom);
      retrig = 1'($urandom);
      clr    = ($urandom_range(0, 7) == 0);
      pin    = pin ^ (4'($urandom) & 4'($urandom));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
